// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 1-to-4 TDM demultiplexer.
package tdm_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  localparam logic [LANE_W-1:0] LANE0 = 2'd0;
  localparam logic [LANE_W-1:0] LANE1 = 2'd1;
  localparam logic [LANE_W-1:0] LANE2 = 2'd2;
  localparam logic [LANE_W-1:0] LANE3 = 2'd3;

endpackage

// File: rtl/tdm_lane_counter.sv
// Wrapping lane index counter; clr beats load1 (restart at lane 1) beats inc.
module tdm_lane_counter
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [LANE_W-1:0] lane
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= LANE0;
    end else if (clr) begin
      lane <= LANE0;
    end else if (load1) begin
      lane <= LANE1;
    end else if (inc) begin
      lane <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/tdm_demux_1x4.sv
// Sequential 1-to-4 TDM demultiplexer: collects four lane words, then updates Y0..Y3 at once.
// Optional frame_err output enabled by defining TDM_DEMUX_FRAME_ERR_EN.
//
//   state | meaning
//   IDLE  | waiting for a sync beat; unsynced beats are dropped
//   RUN   | framing locked; beats fill lanes, lane 3 completes a frame
module tdm_demux_1x4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  Y0,
  output logic [WIDTH-1:0]  Y1,
  output logic [WIDTH-1:0]  Y2,
  output logic [WIDTH-1:0]  Y3,
  output logic              out_valid,
  output logic [LANE_W-1:0] lane,
  output logic              busy
`ifdef TDM_DEMUX_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  state_t           state;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic             accept;
  logic             restart;
  logic             advance;

  // A sync beat restarts at lane 1 unless it lands on lane 0 of a running frame.
  always_comb begin
    accept  = in_valid & ~clr;
    restart = accept & in_sync & ((state == IDLE) | (lane != LANE0));
    advance = accept & (state == RUN) & ~restart;
  end

  tdm_lane_counter u_lane_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load1 (restart),
    .inc   (advance),
    .lane  (lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      sh0       <= '0;
      sh1       <= '0;
      sh2       <= '0;
      Y0        <= '0;
      Y1        <= '0;
      Y2        <= '0;
      Y3        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        state <= IDLE;
        busy  <= 1'b0;
        sh0   <= '0;
        sh1   <= '0;
        sh2   <= '0;
      end else if (restart) begin
        state <= RUN;
        busy  <= 1'b1;
        sh0   <= in_data;
      end else if (advance) begin
        case (lane)
          LANE0: sh0 <= in_data;
          LANE1: sh1 <= in_data;
          LANE2: sh2 <= in_data;
          default: begin
            Y0        <= sh0;
            Y1        <= sh1;
            Y2        <= sh2;
            Y3        <= in_data;
            out_valid <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef TDM_DEMUX_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept & (((state == IDLE) & ~in_sync) |
                             ((state == RUN) & in_sync & (lane != LANE0)));
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Self-checking bench for tdm_demux_1x4 against a queue-based frame model.
module tb_tdm_demux_1x4;

  localparam int W = 1;
  localparam int VW = 4 * W + 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sync = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] Y0, Y1, Y2, Y3;
  logic         out_valid;
  logic [1:0]   lane;
  logic         busy;
  logic         fe_obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_demux_1x4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_data   (in_data),
    .Y0        (Y0),
    .Y1        (Y1),
    .Y2        (Y2),
    .Y3        (Y3),
    .out_valid (out_valid),
    .lane      (lane),
    .busy      (busy)
`ifdef TDM_DEMUX_FRAME_ERR_EN
    ,
    .frame_err (fe_obs)
`endif
  );

`ifndef TDM_DEMUX_FRAME_ERR_EN
  assign fe_obs = 1'b0;
`endif

  // Reference model: words of the frame in progress, lock flag, last frame.
  logic [W-1:0] m_frame[$];
  bit           m_active;
  logic [W-1:0] m_y[4];
  bit           m_ov;
  bit           m_err;
  int           err_count;

  function automatic logic [VW-1:0] obs_vec();
    return {Y0, Y1, Y2, Y3, out_valid, lane, busy, fe_obs};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic fe;
`ifdef TDM_DEMUX_FRAME_ERR_EN
    fe = m_err;
`else
    fe = 1'b0;
`endif
    return {m_y[0], m_y[1], m_y[2], m_y[3], m_ov, 2'(m_frame.size()), m_active, fe};
  endfunction

  task automatic model_reset();
    m_frame.delete();
    m_active = 0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
    m_ov = 0;
    m_err = 0;
  endtask

  task automatic model_edge(input bit v, input bit s, input logic [W-1:0] d, input bit c);
    m_ov = 0;
    m_err = 0;
    if (c) begin
      m_frame.delete();
      m_active = 0;
    end else if (v) begin
      if (!m_active) begin
        if (s) begin
          m_frame.delete();
          m_frame.push_back(d);
          m_active = 1;
        end else begin
          m_err = 1;
        end
      end else if (s && m_frame.size() != 0) begin
        m_err = 1;
        m_frame.delete();
        m_frame.push_back(d);
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 4) begin
          for (int i = 0; i < 4; i++) m_y[i] = m_frame[i];
          m_frame.delete();
          m_ov = 1;
        end
      end
    end
    if (m_err) err_count++;
  endtask

  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit c);
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    model_edge(v, s, d, c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sync = 1'b0;
    clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0);
      checks++;
      if (obs_vec() !== exp_vec() || obs_vec() !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic_frame();
    logic [3:0] pat = 4'b1011;
    int ov_seen = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1, i == 0, W'(pat[3-i]), 0);
      else step(0, 0, '0, 0);
      ov_seen += out_valid;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic_frame cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      if (i == 3) begin
        checks++;
        if ({Y0[0], Y1[0], Y2[0], Y3[0], out_valid, lane, busy} !== 8'b1011_1_00_1) begin
          failures++;
          $display("FAIL basic_values got=%b exp=%b", {Y0[0], Y1[0], Y2[0], Y3[0], out_valid, lane, busy}, 8'b10111001);
        end
      end
    end
    checks++;
    if (ov_seen != 1) begin
      failures++;
      $display("FAIL basic_ov_count got=%0d exp=1", ov_seen);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] pat = 8'b1111_0001;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, W'(pat[7-i]), 0);
      checks++;
      if (obs_vec() !== exp_vec() || out_valid !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL continuous cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({Y0[0], Y1[0], Y2[0], Y3[0]} !== 4'b0001) begin
      failures++;
      $display("FAIL continuous_frame2 got=%b exp=0001", {Y0[0], Y1[0], Y2[0], Y3[0]});
    end
  endtask

  task automatic test_resync();
    logic [5:0] dat = 6'b110101;
    logic [5:0] syn = 6'b101000;
    int errs_before;
    do_reset();
    errs_before = err_count;
    for (int i = 0; i < 6; i++) begin
      step(1, syn[5-i], W'(dat[5-i]), 0);
      checks++;
      if (obs_vec() !== exp_vec() || (i < 5 && out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL resync cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({Y0[0], Y1[0], Y2[0], Y3[0], out_valid} !== 5'b0101_1 || err_count - errs_before != 1) begin
      failures++;
      $display("FAIL resync_frame got=%b exp=01011", {Y0[0], Y1[0], Y2[0], Y3[0], out_valid});
    end
  endtask

  task automatic test_gaps_idle_drop();
    logic [3:0] pat = 4'b1100;
    int ov_seen = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, W'(1), 0);
      checks++;
      if (obs_vec() !== exp_vec() || lane !== 2'd0) begin
        failures++;
        $display("FAIL idle_drop cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        if (g == 0) step(1, b == 0, W'(pat[3-b]), 0);
        else if (b < 3) step(0, 1, W'(1), 0);
        else step(0, 0, '0, 0);
        ov_seen += out_valid;
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL gaps b=%0d g=%0d got=%b exp=%b", b, g, obs_vec(), exp_vec());
        end
      end
    end
    checks++;
    if ({Y0[0], Y1[0], Y2[0], Y3[0]} !== 4'b1100 || ov_seen != 1) begin
      failures++;
      $display("FAIL gaps_frame got=%b ov=%0d exp=1100 ov=1", {Y0[0], Y1[0], Y2[0], Y3[0]}, ov_seen);
    end
  endtask

  task automatic test_clr_and_reset();
    logic [W-1:0] y_keep[4];
    do_reset();
    for (int i = 0; i < 4; i++) step(1, i == 0, W'(i == 1), 0);
    for (int i = 0; i < 4; i++) y_keep[i] = m_y[i];
    step(1, 1, W'(1), 0);
    step(1, 0, W'(1), 0);
    step(1, 0, W'(1), 1);
    checks++;
    if (obs_vec() !== exp_vec() || lane !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        {Y0, Y1, Y2, Y3} !== {y_keep[0], y_keep[1], y_keep[2], y_keep[3]}) begin
      failures++;
      $display("FAIL clr_midframe got=%b exp=%b", obs_vec(), exp_vec());
    end
    step(1, 0, W'(1), 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL after_clr got=%b exp=%b", obs_vec(), exp_vec());
    end
    step(1, 1, W'(1), 0);
    step(1, 0, W'(1), 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs_vec(), {VW{1'b0}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, W'($urandom),
           $urandom_range(0, 39) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    err_count = 0;
    model_reset();
    test_reset();
    test_basic_frame();
    test_continuous();
    test_resync();
    test_gaps_idle_drop();
    test_clr_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Sequential 1-to-4 time-division demultiplexer. It is the receive-side counterpart of the 4x1 mux.
- It accepts a serial stream of words, one lane per accepted beat, with lane 0 marked by a sync flag.
- It collects four words into shadow registers, then presents them together on four registered outputs with a one-cycle valid strobe.
- It sits downstream of a mux-based TDM serializer, so D0..D3 fed into the mux re-emerge on Y0..Y3.

Parameters:
- WIDTH, 1, bit width of each data word/lane.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: abort the current frame and return to IDLE.
- in_valid  input  1  in_data/in_sync are valid this cycle (beat accepted).
- in_sync  input  1  marks the accepted beat as lane 0 (frame start).
- in_data  input  WIDTH  serial data word.
- Y0  output  WIDTH  lane 0 word of the last complete frame.
- Y1  output  WIDTH  lane 1 word.
- Y2  output  WIDTH  lane 2 word.
- Y3  output  WIDTH  lane 3 word.
- out_valid  output  1  one-cycle strobe: Y0..Y3 were updated at this edge.
- lane  output  2  lane index the next accepted beat will fill.
- busy  output  1  high in RUN state.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, lane=0, shadow regs=0, Y0..Y3=0, out_valid=0, busy=0.
- FSM states: IDLE, RUN.
- IDLE:
  - in_valid&in_sync: in_data goes to shadow lane 0, lane<=1, go RUN.
  - in_valid&!in_sync: beat dropped, stay IDLE.
  - No valid: hold.
- RUN, beat with in_sync=0: in_data goes to shadow[lane], lane<=lane+1 (2-bit wrap).
- RUN, beat with in_sync=1 while lane!=0: resync. The partial frame is discarded, in_data goes to shadow lane 0, lane<=1, no out_valid.
- RUN, beat with in_sync=1 while lane==0: normal lane 0 beat. Sync is optional at lane 0 for continuous streams.
- Frame completion, on an accepted beat with lane==3:
  - At the same edge, Y0..Y2<=shadow[0..2], Y3<=in_data, out_valid<=1, lane<=0.
  - State stays RUN.
  - Latency: the last word is visible on Y3 one cycle after its sampling edge.
- out_valid is high for exactly one cycle per completed frame, with no back-to-back gaps required. Four consecutive beats per frame give out_valid every 4th cycle.
- Y0..Y3 hold their values until the next completed frame. They are never partially updated.
- No in_valid in RUN: all state holds; gaps between beats are allowed.
- clr=1: next edge forces IDLE, lane=0, shadow=0, out_valid=0. Y0..Y3 are retained.
  - clr has priority over a simultaneous in_valid, and that beat is dropped.
- Reset mid-frame: immediate return to reset values; partial frame lost.
- busy = (state==RUN), registered. lane is the registered counter value.

Optional Feature:
- Macro: TDM_DEMUX_FRAME_ERR_EN.
- When defined, add output port frame_err (1 bit, reset 0). It pulses high for one cycle at the edge where a resync occurs (RUN, in_sync=1, lane!=0).
- It also pulses for a dropped beat in IDLE (in_valid&!in_sync).
- It does not pulse when clr drops a beat.
- When undefined, the port and its logic are absent; data behaviour is identical.

Decomposition:
- Package tdm_demux_pkg holds:
  - the state typedef (IDLE, RUN);
  - constant LANES=4;
  - constant LANE_W=2;
  - lane index constants LANE0..LANE3.
- Natural sub-module: tdm_lane_counter, a 2-bit wrapping counter with inputs inc, load1 (sync restart) and clr, and output lane.
- The top-level FSM, shadow registers and output registers stay in tdm_demux_1x4.

Test Plan:
- Reset then idle: hold rst_n=0, release, no valid. Required: Y0..Y3=0, out_valid=0, lane=0, busy=0.
- Basic frame (WIDTH=1): beats 1(sync),0,1,1 on consecutive cycles. Required: one out_valid cycle after the 4th beat, with Y0=1, Y1=0, Y2=1, Y3=1, lane=0, busy=1.
- Continuous stream: frame 1,1,1,1 then 0,0,0,1 with no sync on the second frame. Required: out_valid every 4 cycles; second frame gives Y0..Y3=0,0,0,1.
- Resync: sync beat 1, beat 1, then a sync beat 0, followed by 1,0,1. Required:
  - no out_valid after the first two beats;
  - after the last beat, Y0..Y3=0,1,0,1;
  - with TDM_DEMUX_FRAME_ERR_EN, frame_err pulses once at the resync edge.
- Gaps and IDLE drop: beats without sync in IDLE are dropped (lane stays 0). Then a sync frame 1,1,0,0 with in_valid low for 2 cycles between beats. Required: Y0..Y3=1,1,0,0, with a single out_valid.
- clr and async reset mid-frame: after 2 beats, assert clr together with in_valid. Required: lane=0, busy=0, Y retained, no out_valid. Repeat with rst_n low mid-frame. Required: all outputs 0 immediately, before any clock edge.
